// File: rtl/mux_rr_stage.sv
// mux_rr_stage: N-channel registered multiplexer with valid/ready handshakes.
// Selects one requesting channel per cycle (round-robin or fixed by sel)
// and captures its word into a single output register stage.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   per-channel request (bit i = channel i)
//   in_data    channel i at [i*WIDTH +: WIDTH]
//   in_ready   per-channel accept, at most one bit high
//   sel        channel index when MODE=1 (>= NCH selects nothing)
//   out_valid  output register holds a word
//   out_data   registered word
//   out_ch     channel that supplied out_data
//   out_ready  consumer accept
module mux_rr_stage #(
    parameter int WIDTH = 4,
    parameter int NCH   = 4,
    parameter int MODE  = 0,
    parameter int SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic [NCH-1:0]       in_ready,
    input  logic [SELW-1:0]      sel,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    input  logic                 out_ready
);
    logic [SELW-1:0] ptr;
    logic [SELW-1:0] gidx;
    logic            hit;
    logic            load_en;

    assign load_en = !out_valid || out_ready;

    // Scan offsets from the far end down so the nearest requester after ptr wins.
    always_comb begin
        hit  = 1'b0;
        gidx = '0;
        if (MODE == 1) begin
            for (int i = 0; i < NCH; i++) begin
                if (SELW'(i) == sel && in_valid[i]) begin
                    hit  = 1'b1;
                    gidx = SELW'(i);
                end
            end
        end else begin
            for (int k = NCH - 1; k >= 0; k--) begin
                int idx;
                idx = int'(ptr) + k;
                idx = (idx >= NCH) ? idx - NCH : idx;
                if (in_valid[idx]) begin
                    hit  = 1'b1;
                    gidx = SELW'(idx);
                end
            end
        end
    end

    assign in_ready = (load_en && hit) ? ({{(NCH-1){1'b0}}, 1'b1} << gidx) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else if (load_en && hit) begin
            out_valid <= 1'b1;
            out_data  <= in_data[int'(gidx)*WIDTH +: WIDTH];
            out_ch    <= gidx;
            if (MODE == 0)
                ptr <= (int'(gidx) == NCH - 1) ? '0 : gidx + 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mux_rr_stage.sv
// tb_mux_rr_stage: checks a round-robin (NCH=4) and a fixed-select (NCH=3) instance against a behavioural model.
module tb_mux_rr_stage;
    localparam int W  = 4;
    localparam int N0 = 4;
    localparam int N1 = 3;
    localparam int SW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [N0-1:0]     in_valid = '0;
    logic [N0*W-1:0]   in_data = '0;
    logic [SW-1:0]     sel = '0;
    logic              out_ready = 1'b0;
    logic [N1-1:0]     in_valid1;
    logic [N1*W-1:0]   in_data1;

    logic [N0-1:0] rdy0;
    logic          v0;
    logic [W-1:0]  od0;
    logic [SW-1:0] oc0;
    logic [N1-1:0] rdy1;
    logic          v1;
    logic [W-1:0]  od1;
    logic [SW-1:0] oc1;

    assign in_valid1 = in_valid[N1-1:0];
    assign in_data1  = in_data[N1*W-1:0];

    always #5 clk = ~clk;

    mux_rr_stage #(.WIDTH(W), .NCH(N0), .MODE(0)) d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy0),
        .sel(sel), .out_valid(v0), .out_data(od0), .out_ch(oc0), .out_ready(out_ready));

    mux_rr_stage #(.WIDTH(W), .NCH(N1), .MODE(1)) d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_data(in_data1), .in_ready(rdy1),
        .sel(sel), .out_valid(v1), .out_data(od1), .out_ch(oc1), .out_ready(out_ready));

    int vecs = 0;
    int errs = 0;

    int ptr0;
    bit mv0, mv1;
    int md0, mc0, md1, mc1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_pick(input int p, input logic [N0-1:0] v);
        for (int k = 0; k < N0; k++)
            if (v[(p + k) % N0]) return (p + k) % N0;
        return -1;
    endfunction

    function automatic int fx_pick(input int s, input logic [N1-1:0] v);
        if (s < N1) return v[s] ? s : -1;
        return -1;
    endfunction

    function automatic int word(input int c);
        logic [N0*W-1:0] t;
        t = in_data >> (c * W);
        return int'(t[W-1:0]);
    endfunction

    task automatic model_reset();
        ptr0 = 0; mv0 = 0; md0 = 0; mc0 = 0;
        mv1 = 0; md1 = 0; mc1 = 0;
    endtask

    task automatic check_outs(input string tag);
        check({tag, "_v0"}, v0, mv0);
        check({tag, "_d0"}, od0, md0);
        check({tag, "_c0"}, oc0, mc0);
        check({tag, "_v1"}, v1, mv1);
        check({tag, "_d1"}, od1, md1);
        check({tag, "_c1"}, oc1, mc1);
    endtask

    // Called just after a rising edge; checks ready before the next edge and outputs after it.
    task automatic cycle();
        int g0, g1, w0, w1;
        bit l0, l1;
        #1;
        g0 = rr_pick(ptr0, in_valid);
        g1 = fx_pick(int'(sel), in_valid[N1-1:0]);
        l0 = !mv0 || out_ready;
        l1 = !mv1 || out_ready;
        w0 = (g0 >= 0) ? word(g0) : 0;
        w1 = (g1 >= 0) ? word(g1) : 0;
        check("rdy0", rdy0, (l0 && g0 >= 0) ? (1 << g0) : 0);
        check("rdy1", rdy1, (l1 && g1 >= 0) ? (1 << g1) : 0);
        @(posedge clk);
        if (rst_n) begin
            if (l0 && g0 >= 0) begin
                mv0 = 1; md0 = w0; mc0 = g0; ptr0 = (g0 + 1) % N0;
            end else if (out_ready) mv0 = 0;
            if (l1 && g1 >= 0) begin
                mv1 = 1; md1 = w1; mc1 = g1;
            end else if (out_ready) mv1 = 0;
        end
        #1;
        check_outs("out");
    endtask

    task automatic drive(input logic [3:0] v, input logic [15:0] d, input logic [1:0] s, input logic r);
        in_valid = v; in_data = d; sel = s; out_ready = r;
    endtask

    // Pulses reset between edges; outputs must clear without a clock edge.
    task automatic reset_dut();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outs("rst");
        rst_n = 1'b1;
    endtask

    initial begin
        int rc[5] = '{0, 1, 2, 3, 0};
        int rd[5] = '{13, 11, 3, 7, 13};
        int sw[3] = '{3, 1, 3};

        in_valid = N0'($urandom); in_data = 16'($urandom); sel = SW'($urandom); out_ready = 1'($urandom);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_outs("rst_init");
        cycle();
        cycle();

        drive(4'hF, 16'h73BD, 2'd0, 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("rr_ch", oc0, rc[i]);
            check("rr_data", od0, rd[i]);
        end

        reset_dut();
        drive(4'b0010, 16'h0000, 2'd0, 1'b1);
        cycle();
        drive(4'b1010, 16'h5000, 2'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("wrap_ch", oc0, sw[i]);
        end

        drive(4'b0001, 16'h000C, 2'd0, 1'b1);
        cycle();
        check("bp_load", od0, 12);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = N0'($urandom); in_data = 16'($urandom); sel = SW'($urandom);
            cycle();
            check("bp_hold", od0, 12);
            check("bp_valid", v0, 1);
            check("bp_rdy", rdy0, 0);
        end
        drive(4'b0001, 16'h0005, 2'd0, 1'b1);
        cycle();
        check("bp_drain", od0, 5);

        reset_dut();
        drive(4'b0101, 16'h0A03, 2'd2, 1'b1);
        cycle();
        check("fx_rdy", rdy1, 3'b100);
        check("fx_data", od1, 10);
        check("fx_ch", oc1, 2);
        drive(4'b0001, 16'h0A03, 2'd2, 1'b1);
        cycle();
        check("fx_drop", v1, 0);
        drive(4'b0111, 16'h0FFF, 2'd3, 1'b1);
        cycle();
        check("fx_oob", rdy1, 0);

        drive(4'b1111, 16'h1234, 2'd1, 1'b1);
        cycle();
        out_ready = 1'b0;
        cycle();
        check("mid_v", v0, 1);
        reset_dut();
        drive(4'b0110, 16'h0980, 2'd1, 1'b1);
        cycle();
        check("mid_first", oc0, 1);

        for (int n = 0; n < 400; n++) begin
            in_valid = N0'($urandom);
            in_data = 16'($urandom);
            sel = SW'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) reset_dut();
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
